// File: rtl/ad9517_pkg.sv
// Shared types and constants for the AD9517 configuration path
// (SPI master and the sequencer that drives it).
package ad9517_pkg;

  // SPI master transaction phases
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  // Part identification byte returned by the chip ID register
  localparam logic [7:0] AD9517_ID = 8'h53;

  // A read frame starts with a 16-bit instruction: {R/W=1, W1, W0, A[12:0]}
  localparam int RD_INSTR_BITS = 16;

  // Default frame widths and serial timing (clk cycles)
  localparam int SPI_MOSI_WIDTH = 24;
  localparam int SPI_MISO_WIDTH = 8;
  localparam int SPI_CLK_DIV    = 4;
  localparam int SPI_CS_SETUP   = 2;
  localparam int SPI_CS_HOLD    = 2;
  localparam int SPI_CS_IDLE    = 2;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: CLK_DIV clk cycles low then CLK_DIV cycles high per bit,
// with one-cycle strobes marking the clk edge on which SCLK rises or falls.
// Held low and cleared whenever i_en is low.
module spi_sclk_gen
  import ad9517_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] L_DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div_cnt;
  logic       r_sclk;
  logic       w_edge;

  assign w_edge = i_en & (r_div_cnt == L_DIV_LAST);

  // Divider: reload at every half-period boundary and toggle SCLK there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= 8'd0;
      r_sclk    <= 1'b0;
    end else if (!i_en) begin
      r_div_cnt <= 8'd0;
      r_sclk    <= 1'b0;
    end else if (w_edge) begin
      r_div_cnt <= 8'd0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

  assign o_sclk = r_sclk;
  assign o_rise = w_edge & ~r_sclk;
  assign o_fall = w_edge &  r_sclk;

endmodule

// File: rtl/ad9517_spi_master.sv
// AD9517 SPI master: one register write (24-bit frame) or read
// (16-bit instruction + 8 data bits) per accepted command, SPI mode 0.
// Build option SPI_3WIRE_EN: MISO is replaced by a bidirectional SDIO pin
// with an output-enable that releases the line during the read data phase.
module ad9517_spi_master
  import ad9517_pkg::*;
#(
  parameter int MOSI_DATA_WIDTH = SPI_MOSI_WIDTH,
  parameter int MISO_DATA_WIDTH = SPI_MISO_WIDTH,
  parameter int CLK_DIV         = SPI_CLK_DIV,
  parameter int CS_SETUP        = SPI_CS_SETUP,
  parameter int CS_HOLD         = SPI_CS_HOLD,
  parameter int CS_IDLE         = SPI_CS_IDLE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_spi_wr_cmd,
  input  logic                       i_spi_rd_cmd,
  input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
  output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
  output logic                       o_spi_rd_valid,
  output logic                       o_spi_busy,
  output logic                       o_spi_sclk,
  output logic                       o_spi_cs_n,
  output logic                       o_spi_mosi,
`ifdef SPI_3WIRE_EN
  inout  wire                        io_spi_sdio,
  output logic                       o_spi_sdio_oe
`else
  input  logic                       i_spi_miso
`endif
);

  localparam int BIT_W = $clog2(MOSI_DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] L_LAST_BIT   = BIT_W'(MOSI_DATA_WIDTH - 1);
  localparam logic [7:0]       L_SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0]       L_HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0]       L_IDLE_LAST  = 8'(CS_IDLE - 1);

  spi_state_e                 r_state, w_state_next;
  logic [7:0]                 r_phase_cnt, w_phase_next;
  logic [BIT_W-1:0]           r_bit_cnt, w_bit_next;
  logic                       w_accept, w_last_fall;
  logic                       w_sclk_rise, w_sclk_fall, w_miso;
  logic                       r_is_rd, r_busy, r_cs_n, r_rd_valid;
  logic [MOSI_DATA_WIDTH-1:0] r_shift;
  logic [MISO_DATA_WIDTH-1:0] r_miso_sr, r_rd_data;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state == SHIFT),
    .o_sclk (o_spi_sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // State, phase counter and bit counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_phase_cnt <= 8'd0;
      r_bit_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_phase_cnt <= w_phase_next;
      r_bit_cnt   <= w_bit_next;
    end
  end

  // Next-state logic: fixed-length CS phases around the shift phase
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase_cnt;
    w_bit_next   = r_bit_cnt;
    w_accept     = 1'b0;
    w_last_fall  = 1'b0;
    case (r_state)
      IDLE: begin
        if ((i_spi_wr_cmd | i_spi_rd_cmd) & ~r_busy) begin
          w_accept     = 1'b1;
          w_state_next = SETUP;
          w_phase_next = 8'd0;
          w_bit_next   = '0;
        end
      end
      SETUP: begin
        if (r_phase_cnt == L_SETUP_LAST) begin
          w_state_next = SHIFT;
          w_phase_next = 8'd0;
        end else begin
          w_phase_next = r_phase_cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (w_sclk_fall) begin
          if (r_bit_cnt == L_LAST_BIT) begin
            w_last_fall  = 1'b1;
            w_state_next = HOLD;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (r_phase_cnt == L_HOLD_LAST) begin
          w_state_next = GAP;
          w_phase_next = 8'd0;
        end else begin
          w_phase_next = r_phase_cnt + 8'd1;
        end
      end
      GAP: begin
        if (r_phase_cnt == L_IDLE_LAST) begin
          w_state_next = IDLE;
          w_phase_next = 8'd0;
        end else begin
          w_phase_next = r_phase_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_phase_next = 8'd0;
        w_bit_next   = '0;
      end
    endcase
  end

  // Datapath: frame load/shift, MISO capture, read result and pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_rd    <= 1'b0;
      r_shift    <= '0;
      r_miso_sr  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        // Read wins when both commands are present; a read shifts the
        // instruction then zeros while the part returns its byte.
        r_is_rd <= i_spi_rd_cmd;
        r_shift <= i_spi_rd_cmd ?
                   {i_spi_wr_data[RD_INSTR_BITS-1:0], {(MOSI_DATA_WIDTH-RD_INSTR_BITS){1'b0}}} :
                   i_spi_wr_data;
      end else if (w_sclk_fall) begin
        r_shift <= {r_shift[MOSI_DATA_WIDTH-2:0], 1'b0};
      end
      if (w_sclk_rise) begin
        r_miso_sr <= {r_miso_sr[MISO_DATA_WIDTH-2:0], w_miso};
      end
      if (w_last_fall && r_is_rd) begin
        r_rd_data  <= r_miso_sr;
        r_rd_valid <= 1'b1;
      end
      r_busy <= (w_state_next != IDLE);
      r_cs_n <= !((w_state_next == SETUP) || (w_state_next == SHIFT) ||
                  (w_state_next == HOLD));
    end
  end

  assign o_spi_mosi     = r_shift[MOSI_DATA_WIDTH-1];
  assign o_spi_cs_n     = r_cs_n;
  assign o_spi_busy     = r_busy;
  assign o_spi_rd_data  = r_rd_data;
  assign o_spi_rd_valid = r_rd_valid;

`ifdef SPI_3WIRE_EN
  localparam logic [BIT_W-1:0] L_INSTR_LAST = BIT_W'(RD_INSTR_BITS - 1);
  logic r_sdio_oe;

  // SDIO direction: release after the last instruction bit of a read,
  // take the line back once CS_N is deasserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sdio_oe <= 1'b1;
    end else if (w_sclk_fall && r_is_rd && (r_bit_cnt == L_INSTR_LAST)) begin
      r_sdio_oe <= 1'b0;
    end else if (w_state_next == GAP) begin
      r_sdio_oe <= 1'b1;
    end
  end

  assign io_spi_sdio   = r_sdio_oe ? o_spi_mosi : 1'bz;
  assign w_miso        = io_spi_sdio;
  assign o_spi_sdio_oe = r_sdio_oe;
`else
  assign w_miso = i_spi_miso;
`endif

endmodule

// File: tb/tb_ad9517_spi_master.sv
// Self-checking bench for ad9517_spi_master. The bench plays the AD9517:
// it records MOSI on each SCLK rise and returns a byte during the read data
// phase. Expected frames, timing and read data come from the frame rules.
// Build with SPI_3WIRE_EN to exercise the SDIO variant.
module tb_ad9517_spi_master;

  localparam int W        = 24;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 2;
  localparam int EXP_CS   = CS_SETUP + W * 2 * CLK_DIV + CS_HOLD;
  localparam int EXP_BUSY = EXP_CS + CS_IDLE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_cmd = 1'b0;
  logic        rd_cmd = 1'b0;
  logic [23:0] wr_data = 24'h0;
  logic [7:0]  rd_data;
  logic        rd_valid, busy, sclk, cs_n, mosi;
  logic        miso = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          txn_no = 0;
  logic [7:0]  model_rd = 8'h00;

`ifdef SPI_3WIRE_EN
  wire  sdio;
  logic sdio_oe;
  assign sdio = sdio_oe ? 1'bz : miso;
`endif

  always #5 clk = ~clk;

  ad9517_spi_master #(
    .MOSI_DATA_WIDTH(24), .MISO_DATA_WIDTH(8), .CLK_DIV(CLK_DIV),
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_spi_wr_cmd   (wr_cmd),
    .i_spi_rd_cmd   (rd_cmd),
    .i_spi_wr_data  (wr_data),
    .o_spi_rd_data  (rd_data),
    .o_spi_rd_valid (rd_valid),
    .o_spi_busy     (busy),
    .o_spi_sclk     (sclk),
    .o_spi_cs_n     (cs_n),
    .o_spi_mosi     (mosi),
`ifdef SPI_3WIRE_EN
    .io_spi_sdio    (sdio),
    .o_spi_sdio_oe  (sdio_oe)
`else
    .i_spi_miso     (miso)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction, sampled on falling clk edges.
  // hold: keep the command asserted and present next_data once busy drops.
  // poke: raise both commands for a few cycles in the middle of the frame.
  task automatic run_txn(input logic wr, input logic rd, input logic [23:0] data,
                         input logic [7:0] resp, input bit hold,
                         input logic [23:0] next_data, input bit poke);
    logic        is_rd;
    logic [23:0] exp_frame, frame;
    logic [7:0]  got_rd;
    logic        prev_sclk, prev_cs, prev_mosi;
    int          busy_cnt, cs_cnt, gap_cnt, valid_cnt, rises, mosi_err, oe_err;
    bit          seen, done;
    is_rd     = rd;
    exp_frame = is_rd ? {data[15:0], 8'h00} : data;
    frame = 24'h0; got_rd = 8'h0;
    prev_sclk = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0;
    busy_cnt = 0; cs_cnt = 0; gap_cnt = 0; valid_cnt = 0;
    rises = 0; mosi_err = 0; oe_err = 0;
    seen = 1'b0; done = 1'b0;
    wr_data = data; wr_cmd = wr; rd_cmd = rd;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        busy_cnt++;
        if (!hold) begin wr_cmd = 1'b0; rd_cmd = 1'b0; end
        if (poke && busy_cnt >= 60 && busy_cnt < 64) begin wr_cmd = 1'b1; rd_cmd = 1'b1; end
      end else if (seen) begin
        done = 1'b1;
      end
      if (!cs_n) cs_cnt++;
      if (busy && cs_n && cs_cnt > 0) gap_cnt++;
      if (rd_valid) begin valid_cnt++; got_rd = rd_data; end
      if (!prev_sclk && sclk) begin
`ifdef SPI_3WIRE_EN
        if (sdio_oe !== !(is_rd && rises >= 16)) oe_err++;
`endif
        frame = {frame[22:0], mosi};
        rises++;
      end
      if (prev_sclk && !sclk && rises >= 16 && rises < 24) miso = resp[23 - rises];
      if (!prev_cs && !cs_n && (mosi !== prev_mosi) && !(prev_sclk && !sclk)) mosi_err++;
      prev_sclk = sclk; prev_cs = cs_n; prev_mosi = mosi;
    end
    miso = 1'b0;
    if (hold) wr_data = next_data;
    check_val("txn_done", 32'(done), 32'd1);
    if (is_rd) model_rd = resp;
    check_val("bit_count", 32'(rises), 32'd24);
    check_val("mosi_frame", 32'(frame), 32'(exp_frame));
    check_val("busy_cycles", 32'(busy_cnt), 32'(EXP_BUSY));
    check_val("cs_low_cycles", 32'(cs_cnt), 32'(EXP_CS));
    check_val("cs_gap_cycles", 32'(gap_cnt), 32'(CS_IDLE));
    check_val("mosi_edge", 32'(mosi_err), 32'd0);
    check_val("rd_valid_cnt", 32'(valid_cnt), is_rd ? 32'd1 : 32'd0);
    if (is_rd) check_val("rd_valid_data", 32'(got_rd), 32'(resp));
    check_val("rd_data_hold", 32'(rd_data), 32'(model_rd));
`ifdef SPI_3WIRE_EN
    check_val("sdio_oe", 32'(oe_err), 32'd0);
`endif
    txn_no++;
    $display("txn %0d rd=%0b data=%06h frame=%06h rd_data=%02h busy=%0d",
             txn_no, is_rd, data, frame, rd_data, busy_cnt);
  endtask

  initial begin
    int          rises;
    bit          hit;
    logic        prev_sclk;
    logic [23:0] rdata;
    logic [7:0]  rresp;
    logic        rrd;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_cs_n", 32'(cs_n), 32'd1);
    check_val("rst_sclk", 32'(sclk), 32'd0);
    check_val("rst_mosi", 32'(mosi), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rd_data", 32'(rd_data), 32'd0);
    check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
`ifdef SPI_3WIRE_EN
    check_val("rst_sdio_oe", 32'(sdio_oe), 32'd1);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic write and read of the ID register
    run_txn(1'b1, 1'b0, 24'h000018, 8'h00, 1'b0, 24'h0, 1'b0);
    run_txn(1'b0, 1'b1, 24'h008003, 8'h53, 1'b0, 24'h0, 1'b0);

    // Write command held across two transactions, data changing at busy fall
    run_txn(1'b1, 1'b0, 24'h0A0B5C, 8'h00, 1'b1, 24'h00C3A5, 1'b0);
    run_txn(1'b1, 1'b0, 24'h00C3A5, 8'h00, 1'b0, 24'h0, 1'b0);

    // Both commands together: read wins; mid-frame commands are ignored
    run_txn(1'b1, 1'b1, 24'h00801C, 8'hA6, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("no_requeue", 32'(busy), 32'd0);
    end

    // Reset in the middle of a write at bit 10
    wr_data = 24'h5A5A5A; wr_cmd = 1'b1;
    rises = 0; hit = 1'b0; prev_sclk = 1'b0;
    for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
      @(negedge clk);
      if (busy) wr_cmd = 1'b0;
      if (!prev_sclk && sclk) rises++;
      prev_sclk = sclk;
      if (rises == 10) hit = 1'b1;
    end
    check_val("reset_reach_bit10", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort_cs_n", 32'(cs_n), 32'd1);
    check_val("abort_sclk", 32'(sclk), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_rd_valid", 32'(rd_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_rd = 8'h00;
    repeat (2) @(negedge clk);
    check_val("post_rst_busy", 32'(busy), 32'd0);
    check_val("post_rst_rd_data", 32'(rd_data), 32'd0);
    run_txn(1'b1, 1'b0, 24'h00A5F0, 8'h00, 1'b0, 24'h0, 1'b0);

    // Read returning 0x01, then a write (SDIO direction checked in 3-wire build)
    run_txn(1'b0, 1'b1, 24'h008000, 8'h01, 1'b0, 24'h0, 1'b0);
    run_txn(1'b1, 1'b0, 24'h00321F, 8'h00, 1'b0, 24'h0, 1'b0);

    // Randomised mix of reads and writes
    for (int i = 0; i < 8; i++) begin
      rdata = 24'($urandom);
      rresp = 8'($urandom);
      rrd   = 1'($urandom_range(0, 1));
      run_txn(~rrd, rrd, rdata, rresp, 1'b0, 24'h0, 1'b0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
